core_seq_ctrl: RTL
==================

// Module: core_seq_ctrl
// PURPOSE: Multi-cycle control sequencer for s_core. Owns every datapath control wire left undriven in s_core:
//   PC stall/first-address load, instruction-memory and register-file enables, operand and writeback muxes,
//   ALU operator, branch type and RAM strobes. Also runs the boot-load phase that fills instruction memory
//   and preloads registers through the core's external load ports. Decodes the RV32I word from inst_ram1.
// PARAMETERS
//   RETIRE_W   32  width of the retired-instruction counter
//   LOAD_ONLY  0   1 = i_start ignored; the sequencer stays in IDLE and only accepts load beats (bring-up mode)
// PORTS
//   clk                    in   1   core clock; all state changes on the rising edge
//   rst_n                  in   1   asynchronous active-low reset
//   i_start                in   1   1-cycle pulse: leave IDLE/HALT and boot from i_pc_instr_start_addr
//   i_load_valid           in   1   load beat present on inst_mem_addr/data or load_reg_addr/data
//   i_load_is_reg          in   1   1 = beat targets the register file; 0 = beat targets instruction memory
//   o_load_ready           out  1   beat accepted this cycle when i_load_valid & o_load_ready
//   i_inst                 in   32  instruction word from inst_ram1 (valid in DECODE onward)
//   o_pc_stall             out  1   0 only in the cycle the PC must advance or branch
//   o_pc_writing_first_addr out 1   loads the boot start address into the PC
//   o_instrom_read_en      out  1   instruction-memory read strobe
//   o_instrom_write_en     out  1   instruction-memory write strobe (boot load)
//   o_reg_write_en         out  1   register-file write enable
//   o_reg_rd_ctrl          out  1   1 = register write sourced from load_reg_addr/data
//   o_op1_select           out  1   1 = rs1, 0 = pc
//   o_op2_select           out  1   1 = rs2, 0 = imm
//   o_br_or_return_select  out  1   1 = adder adds 4 (link), 0 = adder adds imm (target)
//   o_addr_sel             out  1   1 = pc+imm target, 0 = ALU target (JALR)
//   o_writeback_sel        out  2   `WB_NO_DATA/`WB_RET_ADDR/`WB_ALU_OUT/`WB_LOAD_DATA
//   o_br_type              out  4   branch unit condition type; `BR_NONE when not branching
//   o_alu_operator         out  5   ALU operator code from GLOBALS.v
//   o_ram_read_en          out  1   data RAM read strobe
//   o_ram_write_en         out  1   data RAM write strobe
//   o_ram_type             out  4   access width from funct3 (byte/half/word)
//   o_ram_sign             out  1   1 = sign-extend load data (LB/LH)
//   o_status               out  2   0 idle/loading, 1 running, 2 halted (ECALL/EBREAK), 3 halted (illegal opcode)
//   o_retired              out  RETIRE_W  instructions completed since the last boot; wraps modulo 2^RETIRE_W
// BEHAVIOUR
// - Reset: state=IDLE. Outputs are 0 except o_pc_stall=1 and o_load_ready=1. o_writeback_sel=`WB_NO_DATA,
//   o_br_type=`BR_NONE, o_status=0, o_retired=0. Reset mid-instruction or mid-load abandons it; no partial strobes.
// - States: IDLE, BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT. Control outputs are Moore outputs of the state
//   plus the decoded i_inst. Every state other than WB holds o_pc_stall=1.
// - IDLE/HALT: o_load_ready=1. A reg beat drives o_reg_rd_ctrl=1 and o_reg_write_en=1 for that cycle only. An imem
//   beat drives o_instrom_write_en=1 for that cycle only. i_start in the same cycle as a beat: the beat completes
//   and the transition to BOOT occurs at the same edge. Outside IDLE/HALT, o_load_ready=0 and beats are ignored.
// - BOOT, 1 cycle: o_pc_writing_first_addr=1, clears o_retired, goes to FETCH. i_start outside IDLE/HALT is ignored.
// - FETCH: o_instrom_read_en=1. DECODE: the opcode is checked. SYSTEM (1110011) goes to HALT, status 2. An opcode
//   outside the RV32I set goes to HALT, status 3. Neither retires. FENCE is treated as a NOP.
// - EXEC: ALU mux and operator are valid. For OP, op1=op2=1. OP-IMM/LOAD/STORE/JALR use op1=1, op2=0.
//   AUIPC uses op1=0, op2=0, `ADD. LUI uses `PASSTHROUGH_OP2. BRANCH uses a compare operator from funct3.
//   JAL/JALR write the link register in EXEC: br_or_return=1, wb=`WB_RET_ADDR, reg_write_en=1.
// - MEM (LOAD/STORE only), 1 cycle: o_ram_read_en=1 or o_ram_write_en=1. LOAD keeps ram_read_en high into WB.
// - WB: o_pc_stall=0 for exactly 1 cycle, then FETCH; o_retired increments. ALU/LUI/AUIPC write with `WB_ALU_OUT;
//   LOAD writes with `WB_LOAD_DATA. The branch unit decides taken: BRANCH drives br_type from funct3 and addr_sel=1.
//   JAL drives addr_sel=1 and JALR addr_sel=0, both with unconditional br_type. br_or_return=0.
// - Writes to rd=x0 still pulse reg_write_en; regs ignores them. Latency: ALU/branch/jump 4 cycles, load/store 5.
// STRUCTURE
// - GLOBALS.v gains the state encodings, RV32I opcode constants, `BR_NONE/`BR_JAL/`BR_JALR and `PASSTHROUGH_OP2.
// - One sub-module, ctrl_decode: a purely combinational i_inst -> operator/selects/br_type/ram_type/legal decoder.
//   The FSM and counters live in core_seq_ctrl. s_core instantiates core_seq_ctrl and wires its ctrl nets to it.
// TESTING
// - Load 4 imem beats and 1 reg beat, then start: exactly 4 instrom_write_en pulses, 1 rd_ctrl write; BOOT pulses first_addr once.
// - ADD x3,x1,x2 (0x002081B3) -> 4-cycle sequence, op1=op2=1, wb=`WB_ALU_OUT in WB, stall low 1 cycle, o_retired=1.
// - LW x5,8(x1) then SW x5,12(x1) -> LW: ram_read_en in MEM+WB, `WB_LOAD_DATA, ram_sign=0; SW: 1 write pulse, no reg write.
// - BEQ x0,x0,-8 -> br_type=BEQ, addr_sel=1, br_or_return=0 in WB. JAL x1,16 -> link write in EXEC with br_or_return=1.
// - ECALL (0x00000073) -> HALT, status=2, no retire. Opcode 0x0000007F -> status=3. i_start from HALT -> BOOT.
// - rst_n low in MEM of a store -> ram_write_en drops asynchronously, state=IDLE, o_retired=0. i_start plus a beat together -> both take effect.

Source files
------------

// File: rtl/core_seq_ctrl_pkg.sv
// Shared encodings for the s_core control sequencer: FSM states, RV32I opcodes,
// writeback/branch/ALU/RAM codes and the decoded-instruction payload.
package core_seq_ctrl_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_OP_W   = 5;
  localparam int unsigned BR_W       = 4;
  localparam int unsigned WB_W       = 2;
  localparam int unsigned RAM_TYPE_W = 4;
  localparam int unsigned STATUS_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE, S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [WB_W-1:0] WB_NO_DATA   = 2'd0;
  localparam logic [WB_W-1:0] WB_RET_ADDR  = 2'd1;
  localparam logic [WB_W-1:0] WB_ALU_OUT   = 2'd2;
  localparam logic [WB_W-1:0] WB_LOAD_DATA = 2'd3;

  localparam logic [BR_W-1:0] BR_NONE = 4'd0;
  localparam logic [BR_W-1:0] BR_BEQ  = 4'd1;
  localparam logic [BR_W-1:0] BR_BNE  = 4'd2;
  localparam logic [BR_W-1:0] BR_BLT  = 4'd3;
  localparam logic [BR_W-1:0] BR_BGE  = 4'd4;
  localparam logic [BR_W-1:0] BR_BLTU = 4'd5;
  localparam logic [BR_W-1:0] BR_BGEU = 4'd6;
  localparam logic [BR_W-1:0] BR_JAL  = 4'd7;
  localparam logic [BR_W-1:0] BR_JALR = 4'd8;

  localparam logic [ALU_OP_W-1:0] ALU_ADD             = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB             = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL             = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT             = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU            = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR             = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL             = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA             = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR              = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND             = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASSTHROUGH_OP2 = 5'd10;

  localparam logic [RAM_TYPE_W-1:0] RAM_NONE = 4'd0;
  localparam logic [RAM_TYPE_W-1:0] RAM_BYTE = 4'd1;
  localparam logic [RAM_TYPE_W-1:0] RAM_HALF = 4'd2;
  localparam logic [RAM_TYPE_W-1:0] RAM_WORD = 4'd4;

  localparam logic [STATUS_W-1:0] STAT_IDLE    = 2'd0;
  localparam logic [STATUS_W-1:0] STAT_RUN     = 2'd1;
  localparam logic [STATUS_W-1:0] STAT_SYS     = 2'd2;
  localparam logic [STATUS_W-1:0] STAT_ILLEGAL = 2'd3;

  typedef struct packed {
    logic                  legal;
    logic                  is_system;
    logic                  is_load;
    logic                  is_store;
    logic                  is_branch;
    logic                  is_jal;
    logic                  is_jalr;
    logic                  writes_alu;
    logic                  op1_sel;
    logic                  op2_sel;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [BR_W-1:0]       br_type;
    logic [RAM_TYPE_W-1:0] ram_type;
    logic                  ram_sign;
  } dec_t;

  // Register/immediate ALU ops; alt selects SUB/SRA.
  function automatic logic [ALU_OP_W-1:0] alu_from_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Load handshake and datapath control nets between the sequencer and s_core.
interface core_seq_ctrl_if;
  import core_seq_ctrl_pkg::*;

  logic                  i_load_valid;
  logic                  i_load_is_reg;
  logic                  o_load_ready;
  logic                  o_pc_stall;
  logic                  o_pc_writing_first_addr;
  logic                  o_instrom_read_en;
  logic                  o_instrom_write_en;
  logic                  o_reg_write_en;
  logic                  o_reg_rd_ctrl;
  logic                  o_op1_select;
  logic                  o_op2_select;
  logic                  o_br_or_return_select;
  logic                  o_addr_sel;
  logic [WB_W-1:0]       o_writeback_sel;
  logic [BR_W-1:0]       o_br_type;
  logic [ALU_OP_W-1:0]   o_alu_operator;
  logic                  o_ram_read_en;
  logic                  o_ram_write_en;
  logic [RAM_TYPE_W-1:0] o_ram_type;
  logic                  o_ram_sign;

  modport master (
    input  i_load_valid, i_load_is_reg,
    output o_load_ready, o_pc_stall, o_pc_writing_first_addr, o_instrom_read_en,
           o_instrom_write_en, o_reg_write_en, o_reg_rd_ctrl, o_op1_select, o_op2_select,
           o_br_or_return_select, o_addr_sel, o_writeback_sel, o_br_type, o_alu_operator,
           o_ram_read_en, o_ram_write_en, o_ram_type, o_ram_sign
  );

  modport slave (
    output i_load_valid, i_load_is_reg,
    input  o_load_ready, o_pc_stall, o_pc_writing_first_addr, o_instrom_read_en,
           o_instrom_write_en, o_reg_write_en, o_reg_rd_ctrl, o_op1_select, o_op2_select,
           o_br_or_return_select, o_addr_sel, o_writeback_sel, o_br_type, o_alu_operator,
           o_ram_read_en, o_ram_write_en, o_ram_type, o_ram_sign
  );
endinterface

// File: rtl/core_seq_ctrl_decode.sv
// Combinational RV32I decoder: instruction word -> class flags, mux selects,
// ALU operator, branch condition and RAM access width.
module core_seq_ctrl_decode
  import core_seq_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output dec_t            dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;
  logic       unused_fields;

  assign opcode        = inst[6:0];
  assign funct3        = inst[14:12];
  assign alt           = inst[30];
  assign unused_fields = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    dec         = '0;
    dec.legal   = 1'b1;
    dec.alu_op  = ALU_ADD;
    dec.br_type = BR_NONE;
    case (opcode)
      OPC_LUI: begin
        dec.writes_alu = 1'b1;
        dec.alu_op     = ALU_PASSTHROUGH_OP2;
      end
      OPC_AUIPC: dec.writes_alu = 1'b1;
      OPC_JAL:   dec.is_jal     = 1'b1;
      OPC_JALR: begin
        dec.is_jalr = 1'b1;
        dec.op1_sel = 1'b1;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.op1_sel   = 1'b1;
        dec.op2_sel   = 1'b1;
        case (funct3[2:1])
          2'b10:   dec.alu_op = ALU_SLT;
          2'b11:   dec.alu_op = ALU_SLTU;
          default: dec.alu_op = ALU_SUB;
        endcase
        case (funct3)
          3'b000:  dec.br_type = BR_BEQ;
          3'b001:  dec.br_type = BR_BNE;
          3'b100:  dec.br_type = BR_BLT;
          3'b101:  dec.br_type = BR_BGE;
          3'b110:  dec.br_type = BR_BLTU;
          3'b111:  dec.br_type = BR_BGEU;
          default: dec.br_type = BR_NONE;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec.is_load  = (opcode == OPC_LOAD);
        dec.is_store = (opcode == OPC_STORE);
        dec.op1_sel  = 1'b1;
        // LB/LH sign-extend; LW/LBU/LHU do not
        dec.ram_sign = (opcode == OPC_LOAD) & ~funct3[2] & ~funct3[1];
        case (funct3[1:0])
          2'b00:   dec.ram_type = RAM_BYTE;
          2'b01:   dec.ram_type = RAM_HALF;
          2'b10:   dec.ram_type = RAM_WORD;
          default: dec.ram_type = RAM_NONE;
        endcase
      end
      OPC_OP_IMM: begin
        dec.writes_alu = 1'b1;
        dec.op1_sel    = 1'b1;
        dec.alu_op     = alu_from_funct(funct3, alt & (funct3 == 3'b101));
      end
      OPC_OP: begin
        dec.writes_alu = 1'b1;
        dec.op1_sel    = 1'b1;
        dec.op2_sel    = 1'b1;
        dec.alu_op     = alu_from_funct(funct3, alt);
      end
      OPC_FENCE:  dec.legal     = 1'b1;
      OPC_SYSTEM: dec.is_system = 1'b1;
      default:    dec.legal     = 1'b0;
    endcase
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle control sequencer for s_core: boot-load phase, then
// FETCH/DECODE/EXEC/(MEM)/WB per instruction with halt on SYSTEM or illegal opcode.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int unsigned RETIRE_W  = 32,
  parameter bit          LOAD_ONLY = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [XLEN-1:0]     i_inst,
  core_seq_ctrl_if.master     bus,
  output logic [STATUS_W-1:0] o_status,
  output logic [RETIRE_W-1:0] o_retired
);

  state_t              state_q, state_d;
  logic [STATUS_W-1:0] status_d;
  dec_t                dec;

  core_seq_ctrl_decode u_decode (
    .inst (i_inst),
    .dec  (dec)
  );

  // State, status and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      o_status  <= STAT_IDLE;
      o_retired <= '0;
    end else begin
      state_q  <= state_d;
      o_status <= status_d;
      if (state_q == S_BOOT) begin
        o_retired <= '0;
      end else if (state_q == S_WB) begin
        o_retired <= o_retired + RETIRE_W'(1);
      end
    end
  end

  // Next state and Moore control outputs of state plus decoded instruction
  always_comb begin
    state_d  = state_q;
    status_d = o_status;

    bus.o_load_ready            = 1'b0;
    bus.o_pc_stall              = 1'b1;
    bus.o_pc_writing_first_addr = 1'b0;
    bus.o_instrom_read_en       = 1'b0;
    bus.o_instrom_write_en      = 1'b0;
    bus.o_reg_write_en          = 1'b0;
    bus.o_reg_rd_ctrl           = 1'b0;
    bus.o_op1_select            = 1'b0;
    bus.o_op2_select            = 1'b0;
    bus.o_br_or_return_select   = 1'b0;
    bus.o_addr_sel              = 1'b0;
    bus.o_writeback_sel         = WB_NO_DATA;
    bus.o_br_type               = BR_NONE;
    bus.o_alu_operator          = ALU_ADD;
    bus.o_ram_read_en           = 1'b0;
    bus.o_ram_write_en          = 1'b0;
    bus.o_ram_type              = RAM_NONE;
    bus.o_ram_sign              = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      bus.o_op1_select   = dec.op1_sel;
      bus.o_op2_select   = dec.op2_sel;
      bus.o_alu_operator = dec.alu_op;
    end

    case (state_q)
      S_IDLE, S_HALT: begin
        bus.o_load_ready = 1'b1;
        if (bus.i_load_valid) begin
          bus.o_reg_write_en     = bus.i_load_is_reg;
          bus.o_reg_rd_ctrl      = bus.i_load_is_reg;
          bus.o_instrom_write_en = ~bus.i_load_is_reg;
        end
        if (i_start && !LOAD_ONLY) begin
          state_d  = S_BOOT;
          status_d = STAT_RUN;
        end
      end
      S_BOOT: begin
        bus.o_pc_writing_first_addr = 1'b1;
        state_d                     = S_FETCH;
      end
      S_FETCH: begin
        bus.o_instrom_read_en = 1'b1;
        state_d               = S_DECODE;
      end
      S_DECODE: begin
        if (dec.is_system) begin
          state_d  = S_HALT;
          status_d = STAT_SYS;
        end else if (!dec.legal) begin
          state_d  = S_HALT;
          status_d = STAT_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Jumps write the link register before the PC moves
        if (dec.is_jal || dec.is_jalr) begin
          bus.o_br_or_return_select = 1'b1;
          bus.o_writeback_sel       = WB_RET_ADDR;
          bus.o_reg_write_en        = 1'b1;
        end
        state_d = (dec.is_load || dec.is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.o_ram_read_en  = dec.is_load;
        bus.o_ram_write_en = dec.is_store;
        bus.o_ram_type     = dec.ram_type;
        bus.o_ram_sign     = dec.ram_sign;
        state_d            = S_WB;
      end
      S_WB: begin
        bus.o_pc_stall = 1'b0;
        if (dec.writes_alu) begin
          bus.o_reg_write_en  = 1'b1;
          bus.o_writeback_sel = WB_ALU_OUT;
        end
        if (dec.is_load) begin
          bus.o_reg_write_en  = 1'b1;
          bus.o_writeback_sel = WB_LOAD_DATA;
          bus.o_ram_read_en   = 1'b1;
          bus.o_ram_type      = dec.ram_type;
          bus.o_ram_sign      = dec.ram_sign;
        end
        if (dec.is_branch) begin
          bus.o_br_type  = dec.br_type;
          bus.o_addr_sel = 1'b1;
        end
        if (dec.is_jal) begin
          bus.o_br_type  = BR_JAL;
          bus.o_addr_sel = 1'b1;
        end
        if (dec.is_jalr) begin
          bus.o_br_type  = BR_JALR;
          bus.o_addr_sel = 1'b0;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
